// File: rtl/is_pkg.sv
// is_pkg: shared types and constants for the issue queue
package is_pkg;
  localparam int XLEN      = 32;
  localparam int PREG_BITS = 7;
  localparam int ROB_LEN   = 32;
  localparam int LQ_LEN    = 16;
  localparam int SQ_LEN    = 16;
  localparam logic [PREG_BITS-1:0] PREG_ZERO = '0;
  typedef enum logic [2:0] {
    FU_ALU, FU_MUL, FU_DIV, FU_FALU, FU_FMUL, FU_FDIV, FU_LSU, FU_CSR
  } fu_sel_e;
  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [31:0]                inst;
    logic [XLEN-1:0]            imm;
    logic [6:0]                 op;
    logic [2:0]                 f3;
    logic [6:0]                 f7;
    logic [PREG_BITS-1:0]       P_rs1;
    logic [PREG_BITS-1:0]       P_rs2;
    logic [PREG_BITS-1:0]       P_rd;
    fu_sel_e                    fu_sel;
    logic [$clog2(ROB_LEN)-1:0] rob_idx;
    logic [$clog2(LQ_LEN)-1:0]  LQ_tail;
    logic [$clog2(SQ_LEN)-1:0]  SQ_tail;
    logic                       jump;
  } iq_entry_t;
endpackage

// File: rtl/is_issue_queue_select.sv
// iq_select: lowest-index (oldest) priority picker over a candidate vector
module iq_select #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // isolate lowest set bit and encode its position
  always_comb begin
    grant = req & (~req + 1'b1);
    any   = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/is_issue_queue.sv
// is_issue_queue: collapsing OoO issue queue with wakeup and oldest-ready select; IQ_PERF_EN adds perf counters
module is_issue_queue
  import is_pkg::*;
#(
  parameter int IQ_LEN   = 8,
  parameter int WB_PORTS = 2,
  parameter int PREG_W   = PREG_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       DC_valid,
  input  iq_entry_t                  DC_entry,
  input  logic                       rs1_busy,
  input  logic                       rs2_busy,
  output logic                       IS_ready,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_preg,
  input  logic [7:0]                 fu_ready,
  output logic                       iss_valid,
  output iq_entry_t                  iss_entry,
  input  logic                       mispredict,
  output logic [$clog2(IQ_LEN):0]    iq_count
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]                perf_full_cycles,
  output logic [31:0]                perf_issued
`endif
);
  localparam int IW = $clog2(IQ_LEN);
  localparam int CW = IW + 1;
  logic [IQ_LEN-1:0] valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
  logic [IQ_LEN-1:0] w1, w2, cand, grant;
  iq_entry_t         ent_q [IQ_LEN];
  iq_entry_t         ent_d [IQ_LEN];
  logic [CW-1:0]     count_q, count_d, pos;
  logic [IW-1:0]     sel_idx;
  logic              sel_any, dc_w1, dc_w2, enq, sh;
  int                s;
  // wakeup tag compare for stored slots and the incoming dispatch entry
  always_comb begin
    w1    = '0;
    w2    = '0;
    dc_w1 = 1'b0;
    dc_w2 = 1'b0;
    for (int j = 0; j < WB_PORTS; j++) begin
      if (wb_valid[j] && wb_preg[j*PREG_W +: PREG_W] != PREG_ZERO) begin
        for (int i = 0; i < IQ_LEN; i++) begin
          w1[i] = w1[i] | (ent_q[i].P_rs1 == wb_preg[j*PREG_W +: PREG_W]);
          w2[i] = w2[i] | (ent_q[i].P_rs2 == wb_preg[j*PREG_W +: PREG_W]);
        end
        dc_w1 = dc_w1 | (DC_entry.P_rs1 == wb_preg[j*PREG_W +: PREG_W]);
        dc_w2 = dc_w2 | (DC_entry.P_rs2 == wb_preg[j*PREG_W +: PREG_W]);
      end
    end
  end
  // an entry is a candidate when both operands are ready and its FU can take it
  always_comb begin
    for (int i = 0; i < IQ_LEN; i++) cand[i] = valid_q[i] & r1_q[i] & r2_q[i] & fu_ready[ent_q[i].fu_sel];
  end
  iq_select #(.N(IQ_LEN)) u_sel (
    .req   (cand),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );
  // issue port, backpressure and dispatch acceptance
  always_comb begin
    iss_valid = sel_any && !mispredict;
    iss_entry = iss_valid ? ent_q[sel_idx] : '0;
    IS_ready  = count_q != CW'(IQ_LEN);
    iq_count  = count_q;
    enq       = DC_valid && IS_ready && !mispredict;
  end
  // collapse slots above the issued one, merge wakeups, then place the new entry at the tail
  always_comb begin
    pos     = count_q - CW'(iss_valid);
    sh      = 1'b0;
    s       = 0;
    count_d = mispredict ? '0 : count_q + CW'(enq) - CW'(iss_valid);
    for (int i = 0; i < IQ_LEN; i++) begin
      sh         = sh | (iss_valid & grant[i]);
      s          = (sh && i < IQ_LEN - 1) ? i + 1 : i;
      valid_d[i] = valid_q[s] & ~(sh && i == IQ_LEN - 1);
      ent_d[i]   = ent_q[s];
      r1_d[i]    = r1_q[s] | w1[s];
      r2_d[i]    = r2_q[s] | w2[s];
      if (enq && pos == CW'(i)) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = DC_entry;
        r1_d[i]    = !rs1_busy || DC_entry.P_rs1 == PREG_ZERO || dc_w1;
        r2_d[i]    = !rs2_busy || DC_entry.P_rs2 == PREG_ZERO || dc_w2;
      end
      valid_d[i] = valid_d[i] & ~mispredict;
    end
  end
  // state registers; payloads need no reset because valid gates them
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (rst) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      count_q <= count_d;
    end
  end
`ifdef IQ_PERF_EN
  logic [31:0] full_q, full_d, issued_q, issued_d;
  // saturating occupancy and issue counters
  always_comb begin
    full_d   = (count_q == CW'(IQ_LEN) && ~&full_q) ? full_q + 32'd1 : full_q;
    issued_d = (iss_valid && ~&issued_q) ? issued_q + 32'd1 : issued_q;
    perf_full_cycles = full_q;
    perf_issued      = issued_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      issued_q <= '0;
    end else begin
      full_q   <= full_d;
      issued_q <= issued_d;
    end
  end
`endif
endmodule

// File: tb/tb_is_issue_queue.sv
// tb_is_issue_queue: directed scenarios plus randomized run against a queue-based reference model
module tb_is_issue_queue;
  import is_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        DC_valid, rs1_busy, rs2_busy, IS_ready, iss_valid, mispredict;
  iq_entry_t   DC_entry, iss_entry;
  logic [1:0]  wb_valid;
  logic [13:0] wb_preg;
  logic [7:0]  fu_ready;
  logic [3:0]  iq_count;
  int checks = 0;
  int errors = 0;
`ifdef IQ_PERF_EN
  logic [31:0] perf_full_cycles, perf_issued;
`endif

  is_issue_queue dut (
    .clk(clk), .rst(rst), .DC_valid(DC_valid), .DC_entry(DC_entry),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .IS_ready(IS_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_entry(iss_entry), .mispredict(mispredict),
    .iq_count(iq_count)
`ifdef IQ_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_issued(perf_issued)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int p1;
    int p2;
    int fu;
    bit r1;
    bit r2;
  } mdl_t;
  mdl_t q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit v, int pc, int p1, bit b1, int p2, bit b2, int fu);
    DC_entry        = '0;
    DC_entry.pc     = 32'(pc);
    DC_entry.P_rs1  = 7'(p1);
    DC_entry.P_rs2  = 7'(p2);
    DC_entry.P_rd   = 7'(pc);
    DC_entry.fu_sel = fu_sel_e'(3'(fu));
    DC_valid        = v;
    rs1_busy        = b1;
    rs2_busy        = b2;
  endtask

  task automatic set_wb(bit v0, int p0, bit v1, int p1);
    wb_valid = {v1, v0};
    wb_preg  = {7'(p1), 7'(p0)};
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    mispredict = 1'b0;
  endtask

  function automatic bit woken(int p);
    return p != 0 && ((wb_valid[0] && int'(wb_preg[6:0]) == p) || (wb_valid[1] && int'(wb_preg[13:7]) == p));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    fu_ready = 8'hFF;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (iq_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", iq_count); end
    checks++; if (IS_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", IS_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %0b want 0", iss_valid); end
    checks++; if (iss_entry !== '0) begin errors++; $display("FAIL reset_iss_entry got %h want 0", iss_entry); end
  endtask

  task automatic test_basic();
    fu_ready = 8'hFF;
    set_in(1, 'h100, 1, 0, 2, 0, 0);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_same_cycle got %0b want 0", iss_valid); end
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h100) begin errors++; $display("FAIL basic_issue got v=%0b pc=%h want v=1 pc=100", iss_valid, iss_entry.pc); end
    checks++; if (iq_count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", iq_count); end
    cyc();
    checks++; if (iq_count !== 4'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got cnt=%0d v=%0b want 0 0", iq_count, iss_valid); end
  endtask

  task automatic test_wakeup_order();
    fu_ready = 8'hFF;
    set_in(1, 'h200, 12, 1, 3, 0, 0);
    cyc();
    set_in(1, 'h204, 4, 0, 5, 0, 0);
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h204) begin errors++; $display("FAIL order_b_first got v=%0b pc=%h want 1 204", iss_valid, iss_entry.pc); end
    cyc();
    set_wb(1, 12, 0, 0);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL order_wait got %0b want 0", iss_valid); end
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h200) begin errors++; $display("FAIL order_a_woken got v=%0b pc=%h want 1 200", iss_valid, iss_entry.pc); end
    cyc();
  endtask

  task automatic test_bypass();
    fu_ready = 8'hFF;
    set_in(1, 'h300, 20, 1, 0, 1, 0);
    set_wb(0, 0, 1, 20);
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h300) begin errors++; $display("FAIL bypass got v=%0b pc=%h want 1 300", iss_valid, iss_entry.pc); end
    cyc();
    set_in(1, 'h304, 21, 1, 0, 0, 0);
    set_wb(1, 0, 0, 0);
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b0 || iq_count !== 4'd1) begin errors++; $display("FAIL no_bypass got v=%0b cnt=%0d want 0 1", iss_valid, iq_count); end
    mispredict = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_fill();
    fu_ready = 8'h00;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 'h400 + 4 * i, 1, 0, 2, 0, 0);
      cyc();
    end
    idle();
    #1;
    checks++; if (iq_count !== 4'd8 || IS_ready !== 1'b0) begin errors++; $display("FAIL fill_full got cnt=%0d rdy=%0b want 8 0", iq_count, IS_ready); end
    set_in(1, 'h999, 1, 0, 2, 0, 0);
    cyc();
    idle();
    #1;
    checks++; if (iq_count !== 4'd8) begin errors++; $display("FAIL fill_ignore got %0d want 8", iq_count); end
    fu_ready = 8'h01;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'(32'h400 + 4 * i)) begin errors++; $display("FAIL fill_order%0d got v=%0b pc=%h want 1 %h", i, iss_valid, iss_entry.pc, 32'h400 + 4 * i); end
      checks++; if (IS_ready !== (i != 0)) begin errors++; $display("FAIL fill_ready%0d got %0b want %0b", i, IS_ready, i != 0); end
      cyc();
    end
    checks++; if (iq_count !== 4'd0) begin errors++; $display("FAIL fill_empty got %0d want 0", iq_count); end
  endtask

  task automatic test_mispredict();
    fu_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 'h500 + 4 * i, 1, 0, 2, 0, 0);
      cyc();
    end
    set_in(1, 'h5F0, 1, 0, 2, 0, 0);
    set_wb(1, 30, 0, 0);
    fu_ready   = 8'hFF;
    mispredict = 1'b1;
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL mp_no_issue got %0b want 0", iss_valid); end
    cyc();
    idle();
    #1;
    checks++; if (iq_count !== 4'd0 || iss_valid !== 1'b0) begin errors++; $display("FAIL mp_flush got cnt=%0d v=%0b want 0 0", iq_count, iss_valid); end
    cyc();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL mp_stale got %0b want 0", iss_valid); end
  endtask

  task automatic test_fu_block();
    fu_ready = 8'h00;
    set_in(1, 'h600, 1, 0, 2, 0, 2);
    cyc();
    set_in(1, 'h604, 3, 0, 4, 0, 0);
    cyc();
    idle();
    fu_ready = 8'b0000_0001;
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h604) begin errors++; $display("FAIL fu_alu got v=%0b pc=%h want 1 604", iss_valid, iss_entry.pc); end
    cyc();
    checks++; if (iss_valid !== 1'b0 || iq_count !== 4'd1) begin errors++; $display("FAIL fu_div_wait got v=%0b cnt=%0d want 0 1", iss_valid, iq_count); end
    fu_ready = 8'b0000_0100;
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_entry.pc !== 32'h600) begin errors++; $display("FAIL fu_div got v=%0b pc=%h want 1 600", iss_valid, iss_entry.pc); end
    cyc();
  endtask

  task automatic test_mid_reset();
    fu_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 'h700 + 4 * i, 40, 1, 0, 0, 0);
      cyc();
    end
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (iq_count !== 4'd0 || IS_ready !== 1'b1) begin errors++; $display("FAIL midrst got cnt=%0d rdy=%0b want 0 1", iq_count, IS_ready); end
    set_wb(1, 40, 0, 0);
    cyc();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL midrst_lost got %0b want 0", iss_valid); end
  endtask

  task automatic test_random();
    int  k;
    int  pc = 'h1000;
    bit  exp_iss;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 9) < 6, pc, $urandom_range(0, 15), $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7));
      set_wb($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
      fu_ready   = 8'($urandom);
      mispredict = $urandom_range(0, 39) == 0;
      #1;
      k = -1;
      foreach (q[i]) if (k < 0 && q[i].r1 && q[i].r2 && fu_ready[q[i].fu]) k = i;
      exp_iss = k >= 0 && !mispredict;
      checks++; if (iq_count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, iq_count, q.size()); end
      checks++; if (IS_ready !== (q.size() != 8)) begin errors++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, IS_ready, q.size() != 8); end
      checks++; if (iss_valid !== exp_iss) begin errors++; $display("FAIL rnd_iss_valid c=%0d got %0b want %0b", c, iss_valid, exp_iss); end
      checks++;
      if (exp_iss ? iss_entry.pc !== 32'(q[k].pc) : iss_entry !== '0) begin
        errors++; $display("FAIL rnd_iss_entry c=%0d got pc=%h want %h", c, iss_entry.pc, exp_iss ? q[k].pc : 0);
      end
      if (mispredict) q.delete();
      else begin
        bit acc = DC_valid && q.size() != 8;
        foreach (q[i]) begin
          q[i].r1 = q[i].r1 || woken(q[i].p1);
          q[i].r2 = q[i].r2 || woken(q[i].p2);
        end
        if (exp_iss) q.delete(k);
        if (acc) begin
          mdl_t m;
          m.pc = pc;
          m.p1 = int'(DC_entry.P_rs1);
          m.p2 = int'(DC_entry.P_rs2);
          m.fu = int'(DC_entry.fu_sel);
          m.r1 = !rs1_busy || m.p1 == 0 || woken(m.p1);
          m.r2 = !rs2_busy || m.p2 == 0 || woken(m.p2);
          q.push_back(m);
          pc += 4;
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup_order();
    test_bypass();
    test_fill();
    test_mispredict();
    test_fu_block();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
